uart_rx_fsm: RTL and testbench

Receive-side UART frame controller, the counterpart of the TX FSM in the UART block. It oversamples `RX_IN` by a runtime prescale and detects the start bit, rejecting glitches. It recovers `DATA_WIDTH` data bits LSB-first, checks the optional parity bit and the stop bit, then presents the byte with a one-cycle valid strobe and error flags. It sits between the RX synchronizer and the RX data-sync/FIFO path of the system.

---
 rtl/uart_rx_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: receive-side UART frame controller.
// Oversamples RX_IN by a runtime prescale (8/16/32, anything else -> 8),
// rejects start-bit glitches, recovers DATA_WIDTH bits LSB-first, checks
// optional parity and the stop bit, and strobes the result for one cycle.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority vote
// around mid-bit; when undefined a single mid-bit sample is used).
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Only 16 and 32 are honoured; every other prescale runs as 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      6'd16:   r = 6'd16;
      6'd32:   r = 6'd32;
      default: r = 6'd8;
    endcase
    return r;
  endfunction

  // Expected parity bit: XOR of the data for even, XNOR for odd.
  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d,
                                           input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                state;
  state_t                state_nxt;
  logic [5:0]            edge_cnt;
  logic [5:0]            edge_cnt_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic                  par_bad;
  logic                  par_bad_nxt;
  logic                  cfg_load;
  logic                  frame_done;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            pre_q;
  logic [5:0]            mid;
  logic [5:0]            last_edge;
  logic [5:0]            dec_edge;
  logic                  is_dec;
  logic                  is_last;
  logic                  bit_val;

  assign mid       = {1'b0, pre_q[5:1]};
  assign last_edge = pre_q - 6'd1;
  assign is_dec    = (edge_cnt == dec_edge);
  assign is_last   = (edge_cnt == last_edge);

`ifdef UART_RX_MAJORITY_VOTE_EN
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  logic [2:0] smp;

  assign dec_edge = mid + 6'd2;
  assign bit_val  = majority3(smp);

  // Capture three line samples straddling mid-bit for the vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      smp <= 3'b111;
    end else begin
      if (edge_cnt == (mid - 6'd1)) smp[0] <= RX_IN;
      if (edge_cnt == mid)          smp[1] <= RX_IN;
      if (edge_cnt == (mid + 6'd1)) smp[2] <= RX_IN;
    end
  end
`else
  logic smp;

  assign dec_edge = mid + 6'd1;
  assign bit_val  = smp;

  // Capture the single mid-bit line sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      smp <= 1'b1;
    end else if (edge_cnt == mid) begin
      smp <= RX_IN;
    end
  end
`endif

  // Next-state, counter and shift-register decisions
  always_comb begin
    state_nxt    = state;
    edge_cnt_nxt = is_last ? 6'd0 : (edge_cnt + 6'd1);
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_bad_nxt  = par_bad;
    cfg_load     = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          // The detect cycle itself is edge 0 of the start bit.
          state_nxt    = START;
          edge_cnt_nxt = 6'd1;
          par_bad_nxt  = 1'b0;
          cfg_load     = 1'b1;
        end else begin
          edge_cnt_nxt = 6'd0;
        end
      end
      START: begin
        if (is_dec && bit_val) begin
          state_nxt    = IDLE;
          edge_cnt_nxt = 6'd0;
        end else if (is_last) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (is_dec) begin
          shreg_nxt = {bit_val, shreg[DATA_WIDTH-1:1]};
        end else begin
          shreg_nxt = shreg;
        end
        if (is_last) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = par_en_q ? PAR : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end else begin
          state_nxt = DATA;
        end
      end
      PAR: begin
        if (is_dec) begin
          par_bad_nxt = bit_val ^ expected_parity(shreg, par_typ_q);
        end else begin
          par_bad_nxt = par_bad;
        end
        if (is_last) begin
          state_nxt = STOP;
        end else begin
          state_nxt = PAR;
        end
      end
      STOP: begin
        // Leave at the decision point so a following start bit is not missed.
        if (is_dec) begin
          state_nxt    = IDLE;
          edge_cnt_nxt = 6'd0;
          frame_done   = 1'b1;
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt    = IDLE;
        edge_cnt_nxt = 6'd0;
      end
    endcase
  end

  // State, counters, shift register and per-frame configuration latch
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      edge_cnt  <= 6'd0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pre_q     <= 6'd8;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      par_bad  <= par_bad_nxt;
      if (cfg_load) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        pre_q     <= legal_prescale(Prescale);
      end
    end
  end

  // Registered frame result: one-cycle strobes, data held until next good frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= frame_done & bit_val & ~par_bad;
      par_err    <= frame_done & par_bad;
      stp_err    <= frame_done & ~bit_val;
      if (frame_done && bit_val && !par_bad) begin
        P_DATA <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table of single frames with fixed
// expectations, hand-built multi-frame sequences, and a random line waveform
// checked against a frame-level reference model.
module tb_uart_rx_fsm;

  localparam int MAXW = 4096;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DL = 2;
`else
  localparam int DL = 1;
`endif
  localparam int ADJ = 2 - DL;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pd;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         pt;
    logic [5:0] ps;
    bit         flip;
    bit         stopb;
    int         cyc_maj;
    bit         dv;
    bit         perr;
    bit         serr;
    logic [7:0] pd;
  } vec_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  bit         wl [MAXW];
  bit         wr [MAXW];
  bit         wpe[MAXW];
  bit         wpt[MAXW];
  logic [5:0] wps[MAXW];
  int         n_pass = 0;
  int         n_tot  = 0;
  logic [7:0] cur_pd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int eff_p(input logic [5:0] ps);
    if (ps == 6'd16) return 16;
    else if (ps == 6'd32) return 32;
    else return 8;
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < MAXW; i++) begin
      wl[i] = 1'b1; wr[i] = 1'b0; wpe[i] = 1'b0; wpt[i] = 1'b0; wps[i] = 6'd8;
    end
  endtask

  // Transmitter: write one complete frame into the line waveform.
  task automatic put_frame(input int off, input logic [7:0] d, input bit pe, input bit pt,
                           input logic [5:0] ps, input bit flip, input bit stopb);
    int p;
    int s;
    bit b;
    p = eff_p(ps);
    s = pe ? 10 : 9;
    for (int k = 0; k <= s; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= 8) b = d[k-1];
      else if (pe && k == 9) b = (^d) ^ pt ^ flip;
      else b = stopb;
      for (int e = 0; e < p; e++)
        if (off + k*p + e < MAXW) wl[off + k*p + e] = b;
    end
    for (int c = off; c < off + (s+1)*p && c < MAXW; c++) begin
      wpe[c] = pe; wpt[c] = pt; wps[c] = ps;
    end
  endtask

  task automatic add_exp(input int c, input bit dv, input bit pe, input bit se, input logic [7:0] pd);
    exp_q.push_back('{c, dv, pe, se, pd});
  endtask

  // Drive the waveform one clock per entry and log every strobe cycle.
  task automatic run_wave(input int len);
    obs_q.delete();
    for (int i = 0; i < len; i++) begin
      RX_IN = wl[i]; RST = wr[i]; PAR_EN = wpe[i]; PAR_TYP = wpt[i]; Prescale = wps[i];
      @(posedge CLK);
      #1;
      if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1)
        obs_q.push_back('{i+1, data_valid, par_err, stp_err, P_DATA});
    end
    RX_IN = 1'b1;
    RST   = 1'b0;
  endtask

  task automatic cmp_events(input string nm);
    chk({nm, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s[%0d] cycle", nm, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s[%0d] data_valid", nm, i), {31'd0, obs_q[i].dv}, {31'd0, exp_q[i].dv});
      chk($sformatf("%s[%0d] par_err", nm, i), {31'd0, obs_q[i].pe}, {31'd0, exp_q[i].pe});
      chk($sformatf("%s[%0d] stp_err", nm, i), {31'd0, obs_q[i].se}, {31'd0, exp_q[i].se});
      chk($sformatf("%s[%0d] P_DATA", nm, i), {24'd0, obs_q[i].pd}, {24'd0, exp_q[i].pd});
    end
  endtask

  function automatic bit wv(input int idx, input int len);
    return (idx < len) ? wl[idx] : 1'b1;
  endfunction

  // Bit value as the receiver sees it: mid-bit sample or 2-of-3 vote.
  function automatic bit sbit(input int c0, input int k, input int p, input int len);
    int b;
    int ones;
    b = c0 + k*p + p/2;
    if (DL == 2) begin
      ones = int'(wv(b-1, len)) + int'(wv(b, len)) + int'(wv(b+1, len));
      return ones >= 2;
    end
    return wv(b, len);
  endfunction

  // Frame-level reference: walk the line, decode frames, predict strobes.
  task automatic model_wave(input int len);
    int         t;
    int         c0;
    int         p;
    int         s;
    int         dc;
    bit         pe;
    bit         pt;
    bit         perr;
    bit         serr;
    logic [7:0] d;
    t = 0;
    exp_q.delete();
    while (t < len) begin
      if (wl[t]) begin
        t++;
      end else begin
        c0 = t; p = eff_p(wps[t]); pe = wpe[t]; pt = wpt[t];
        if (sbit(c0, 0, p, len)) begin
          t = c0 + p/2 + DL + 1;
        end else begin
          d = '0;
          for (int i = 0; i < 8; i++) d[i] = sbit(c0, i+1, p, len);
          s    = pe ? 10 : 9;
          perr = pe && (sbit(c0, 9, p, len) != ((^d) ^ pt));
          serr = !sbit(c0, s, p, len);
          dc   = c0 + s*p + p/2 + DL;
          if (dc + 1 <= len) begin
            if (!perr && !serr) cur_pd = d;
            add_exp(dc + 1, !perr && !serr, perr, serr, cur_pd);
          end
          t = dc + 1;
        end
      end
    end
  endtask

  initial begin
    vec_t       tbl[7];
    int         off;
    int         w;
    int         flen;
    int         r;
    logic [5:0] ps;
    bit         pe;
    bit         pt;
    logic [7:0] d;

    //        data   pe    pt    ps     flip  stop  cyc  dv    perr  serr  P_DATA
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  1'b0, 1'b1, 79,  1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 6'd16, 1'b0, 1'b1, 171, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1, 171, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 6'd8,  1'b0, 1'b0, 79,  1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 6'd32, 1'b0, 1'b1, 339, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 6'd12, 1'b0, 1'b1, 79,  1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[6] = '{8'h81, 1'b1, 1'b1, 6'd8,  1'b1, 1'b0, 87,  1'b0, 1'b1, 1'b1, 8'hFF};

    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset P_DATA", {24'd0, P_DATA}, 32'd0);
    chk("reset data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset par_err", {31'd0, par_err}, 32'd0);
    chk("reset stp_err", {31'd0, stp_err}, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Single frames with hand-derived results and latencies.
    for (int i = 0; i < 7; i++) begin
      clear_wave();
      put_frame(5, tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].ps, tbl[i].flip, tbl[i].stopb);
      run_wave(420);
      exp_q.delete();
      add_exp(5 + tbl[i].cyc_maj - ADJ, tbl[i].dv, tbl[i].perr, tbl[i].serr, tbl[i].pd);
      cmp_events($sformatf("vec%0d", i));
    end

    // Idle glitch, then a frame with a 1-cycle flip at M-1 of data bit 3
    // and config changed mid-frame.
    clear_wave();
    wl[2] = 1'b0; wl[3] = 1'b0;
    put_frame(20, 8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    wl[20 + 4*8 + 3] = 1'b0;
    for (int c = 21; c < 100; c++) begin wpe[c] = 1'b1; wps[c] = 6'd16; end
    run_wave(200);
    exp_q.delete();
    add_exp(20 + 79 - ADJ, 1'b1, 1'b0, 1'b0, 8'h5A);
    cmp_events("glitch_flip");

    // Back-to-back frames, 80 cycles apart at P=8.
    clear_wave();
    put_frame(0, 8'h01, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    put_frame(80, 8'hFE, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    run_wave(260);
    exp_q.delete();
    add_exp(79 - ADJ, 1'b1, 1'b0, 1'b0, 8'h01);
    add_exp(159 - ADJ, 1'b1, 1'b0, 1'b0, 8'hFE);
    cmp_events("back2back");

    // Low stop bit: stp_err, then the low line is taken as a new start.
    clear_wave();
    put_frame(0, 8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
    put_frame(79, 8'h81, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    run_wave(260);
    r = 79 - ADJ;
    exp_q.delete();
    add_exp(r, 1'b0, 1'b0, 1'b1, 8'hFE);
    add_exp(r + 79 - ADJ, 1'b1, 1'b0, 1'b0, 8'h81);
    cmp_events("stop_as_start");

    // Reset mid-DATA discards the frame (and clears P_DATA); clean frame after.
    clear_wave();
    put_frame(0, 8'h33, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    wr[30] = 1'b1;
    for (int c = 31; c < 100; c++) wl[c] = 1'b1;
    put_frame(100, 8'h7E, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    run_wave(260);
    exp_q.delete();
    add_exp(100 + 79 - ADJ, 1'b1, 1'b0, 1'b0, 8'h7E);
    cmp_events("reset_mid");
    cur_pd = 8'h7E;

    // Random line traffic against the frame-level model.
    clear_wave();
    off = 10;
    while (off < 3000) begin
      if ($urandom_range(0, 4) == 0) begin
        w = $urandom_range(1, 3);
        for (int k = 0; k < w; k++) wl[off + k] = 1'b0;
        off += 40;
      end
      case ($urandom_range(0, 3))
        0:       ps = 6'd8;
        1:       ps = 6'd16;
        2:       ps = 6'd32;
        default: ps = 6'($urandom_range(0, 63));
      endcase
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      put_frame(off, d, pe, pt, ps, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
      flen = (pe ? 11 : 10) * eff_p(ps);
      for (int c = off + 1; c < off + flen; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          wpe[c] = 1'($urandom_range(0, 1));
          wpt[c] = 1'($urandom_range(0, 1));
          wps[c] = 6'($urandom_range(0, 63));
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        w = off + $urandom_range(0, flen - 1);
        wl[w] = ~wl[w];
      end
      off += flen + $urandom_range(0, 12);
    end
    model_wave(3900);
    run_wave(3900);
    cmp_events("random");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
